crop_window: RTL and testbench

Video-stream cropper for the DVP video-processing chain: passes only the pixels inside a run-time rectangular window (x, y, width, height) and drops everything else, so a large sensor frame becomes a smaller output frame. It is the counterpart of the line filler, which pads short lines with black. The cropper shortens lines and frames instead. It sits between a source (camera/DVP capture) and downstream VP stages, on the same vs/de/24-bit data stream.

---
 rtl/crop_window.sv | 173 +++++++++++++++++
 tb/tb_crop_window.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/crop_window.sv
// crop_window: keeps only the pixels of a DVP-style vs/de/data stream that
// fall inside a run-time rectangle (x, y, w, h). The window is latched at each
// vs rising edge so the settings stay stable for the whole frame. Outputs are
// registered with exactly one cycle of latency. frame_short flags a frame that
// ended before every window line reached its last kept column.
module crop_window #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [CNT_W-1:0]  crop_x,
  input  logic [CNT_W-1:0]  crop_y,
  input  logic [CNT_W-1:0]  crop_w,
  input  logic [CNT_W-1:0]  crop_h,
  input  logic              pre_vs,
  input  logic              pre_de,
  input  logic [DATA_W-1:0] pre_data,
  output logic              post_vs,
  output logic              post_de,
  output logic [DATA_W-1:0] post_data,
  output logic              frame_short
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // input history for edge detection
  logic vs_q;
  logic de_q;

  // per-frame shadow copy of the window settings
  logic             en_s_q;
  logic [CNT_W-1:0] xs_q;
  logic [CNT_W-1:0] ys_q;
  logic [CNT_W-1:0] ws_q;
  logic [CNT_W-1:0] hs_q;

  // position counters and full-line bookkeeping
  logic [CNT_W-1:0] px_q, px_d;
  logic [CNT_W-1:0] ly_q, ly_d;
  logic [CNT_W-1:0] kept_q, kept_d;
  logic             hit_q, hit_d;
  logic             fs_q, fs_d;

  // registered outputs
  logic              post_vs_q;
  logic              post_de_q;
  logic [DATA_W-1:0] post_data_q;

  logic           vs_rise;
  logic           de_fall;
  logic [CNT_W:0] x_end;
  logic [CNT_W:0] y_end;
  logic [CNT_W:0] x_last;
  logic           in_win;
  logic           keep;
  logic           last_col;

  assign vs_rise = pre_vs & ~vs_q;
  assign de_fall = de_q & ~pre_de;

  // Window ends are one bit wider so a window running past the counter range
  // clips instead of wrapping back to small coordinates.
  assign x_end  = {1'b0, xs_q} + {1'b0, ws_q};
  assign y_end  = {1'b0, ys_q} + {1'b0, hs_q};
  assign x_last = x_end - (CNT_W+1)'(1);

  assign in_win = ({1'b0, px_q} >= {1'b0, xs_q}) & ({1'b0, px_q} < x_end) &
                  ({1'b0, ly_q} >= {1'b0, ys_q}) & ({1'b0, ly_q} < y_end);

  assign keep = pre_de & ~pre_vs & (~en_s_q | in_win);

  // A line counts as fully kept once it delivers its last window column.
  // hit_q stops a saturated pixel counter from counting the same line twice.
  assign last_col = keep & en_s_q & ~hit_q & ({1'b0, px_q} == x_last);

  // edge history and shadow load at the start of each frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      en_s_q <= 1'b0;
      xs_q   <= '0;
      ys_q   <= '0;
      ws_q   <= '0;
      hs_q   <= '0;
    end else begin
      vs_q <= pre_vs;
      de_q <= pre_de;
      if (vs_rise) begin
        en_s_q <= EN;
        xs_q   <= crop_x;
        ys_q   <= crop_y;
        ws_q   <= crop_w;
        hs_q   <= crop_h;
      end
    end
  end

  // next-state for pixel/line counters, kept-line count and frame_short
  always_comb begin
    px_d   = px_q;
    ly_d   = ly_q;
    kept_d = kept_q;
    hit_d  = hit_q;
    fs_d   = fs_q;
    if (pre_vs) begin
      px_d  = '0;
      ly_d  = '0;
      hit_d = 1'b0;
    end else begin
      if (pre_de) begin
        px_d = (px_q == CNT_MAX) ? px_q : px_q + CNT_W'(1);
      end else begin
        px_d = '0;
      end
      if (de_fall && (ly_q != CNT_MAX)) begin
        ly_d = ly_q + CNT_W'(1);
      end
      if (!pre_de) begin
        hit_d = 1'b0;
      end else if (last_col) begin
        hit_d = 1'b1;
      end
      if (last_col && (kept_q != CNT_MAX)) begin
        kept_d = kept_q + CNT_W'(1);
      end
    end
    // Judge the ending frame against the window it was cropped with, then
    // restart the count for the new frame.
    if (vs_rise) begin
      fs_d   = en_s_q & (hs_q != '0) & (kept_q < hs_q);
      kept_d = '0;
    end
  end

  // counter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_q   <= '0;
      ly_q   <= '0;
      kept_q <= '0;
      hit_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      px_q   <= px_d;
      ly_q   <= ly_d;
      kept_q <= kept_d;
      hit_q  <= hit_d;
      fs_q   <= fs_d;
    end
  end

  // one-cycle output stage; dropped pixels leave zero on the data bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_vs_q   <= 1'b0;
      post_de_q   <= 1'b0;
      post_data_q <= '0;
    end else begin
      post_vs_q   <= pre_vs;
      post_de_q   <= keep;
      post_data_q <= keep ? pre_data : '0;
    end
  end

  assign post_vs     = post_vs_q;
  assign post_de     = post_de_q;
  assign post_data   = post_data_q;
  assign frame_short = fs_q;

endmodule

// File: tb/tb_crop_window.sv
// tb_crop_window: scoreboard bench for crop_window. The frame driver keeps its
// own copy of the latched window, pushes every pixel it expects to survive,
// and a cycle monitor pops and compares each pixel the DUT emits.
module tb_crop_window;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              EN;
  logic [CNT_W-1:0]  crop_x, crop_y, crop_w, crop_h;
  logic              pre_vs, pre_de;
  logic [DATA_W-1:0] pre_data;
  logic              post_vs, post_de, frame_short;
  logic [DATA_W-1:0] post_data;

  always #5 clk = ~clk;

  crop_window #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .EN          (EN),
    .crop_x      (crop_x),
    .crop_y      (crop_y),
    .crop_w      (crop_w),
    .crop_h      (crop_h),
    .pre_vs      (pre_vs),
    .pre_de      (pre_de),
    .pre_data    (pre_data),
    .post_vs     (post_vs),
    .post_de     (post_de),
    .post_data   (post_data),
    .frame_short (frame_short)
  );

  int                n_cmp = 0;
  int                n_err = 0;
  int                frame_no = 0;
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] mon_exp;

  // window as the DUT should have latched it at the last vs rising edge
  bit m_en = 1'b0;
  int m_x = 0, m_y = 0, m_w = 0, m_h = 0;
  bit exp_fs = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (frame %0d, t=%0t)", tag, got, exp, frame_no, $time);
    end
  endtask

  // per-cycle output monitor, sampled 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    check_eq("post_vs", {31'b0, post_vs}, {31'b0, rst_n ? pre_vs : 1'b0});
    if (!rst_n) begin
      check_eq("rst_post_de", {31'b0, post_de}, 32'd0);
      check_eq("rst_post_data", {8'b0, post_data}, 32'd0);
      check_eq("rst_frame_short", {31'b0, frame_short}, 32'd0);
    end else if (post_de) begin
      check_eq("sb_available", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check_eq("post_data", {8'b0, post_data}, {8'b0, mon_exp});
        $display("frame %0d: pixel 0x%06h expected 0x%06h", frame_no, post_data, mon_exp);
      end
    end else begin
      check_eq("idle_post_data", {8'b0, post_data}, 32'd0);
    end
  end

  // one input cycle, applied 2 time units after the active edge
  task automatic drive(input logic vs, input logic de, input logic [DATA_W-1:0] d, input logic rst);
    @(posedge clk);
    #2;
    rst_n    = ~rst;
    pre_vs   = vs;
    pre_de   = de;
    pre_data = d;
  endtask

  // One frame: 3-cycle vs pulse, W x H active area with 3-cycle line gaps.
  // chg_line >= 0 rewrites crop_x at the start of that line; rst_line/rst_col
  // >= 0 pulses reset on that pixel.
  task automatic drive_frame(input int W, input int H, input int base,
                             input int chg_line, input int chg_x,
                             input int rst_line, input int rst_col);
    int  full;
    bit  rst, kp;
    frame_no++;
    check_eq("sb_drained", sb.size(), 32'd0);
    m_en = EN; m_x = crop_x; m_y = crop_y; m_w = crop_w; m_h = crop_h;
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    check_eq("frame_short", {31'b0, frame_short}, {31'b0, exp_fs});
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int l = 0; l < H; l++) begin
      if (l == chg_line) crop_x = CNT_W'(chg_x);
      for (int c = 0; c < W; c++) begin
        rst = (l == rst_line) && (c == rst_col);
        kp  = !rst && (!m_en || (c >= m_x && c < m_x + m_w && l >= m_y && l < m_y + m_h));
        if (kp) sb.push_back(DATA_W'(base + l * 16 + c));
        drive(1'b0, 1'b1, DATA_W'(base + l * 16 + c), rst);
        if (rst) m_en = 1'b0;
      end
      repeat (3) drive(1'b0, 1'b0, '0, 1'b0);
    end
    full = 0;
    if (m_w > 0 && m_x + m_w <= W) begin
      for (int l = 0; l < H; l++) begin
        if (l >= m_y && l < m_y + m_h) full++;
      end
    end
    exp_fs = m_en && (m_h != 0) && (full < m_h);
  endtask

  task automatic set_win(input int x, input int y, input int w, input int h);
    crop_x = CNT_W'(x); crop_y = CNT_W'(y); crop_w = CNT_W'(w); crop_h = CNT_W'(h);
  endtask

  initial begin
    rst_n = 1'b0; EN = 1'b0;
    pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;
    set_win(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);

    // bypass: every pixel passes, delayed one cycle
    EN = 1'b0;
    drive_frame(8, 4, 0, -1, 0, -1, -1);
    drive_frame(8, 4, 'h1000, -1, 0, -1, -1);

    // basic crop x=2 y=1 w=3 h=2
    EN = 1'b1;
    set_win(2, 1, 3, 2);
    drive_frame(8, 4, 0, -1, 0, -1, -1);
    drive_frame(8, 4, 0, -1, 0, -1, -1);

    // mid-frame crop_x change only affects the following frame
    drive_frame(8, 4, 0, 1, 4, -1, -1);
    drive_frame(8, 4, 0, -1, 0, -1, -1);

    // window overruns the line: cols 6,7 only, frame flagged short
    set_win(6, 1, 4, 2);
    drive_frame(8, 4, 0, -1, 0, -1, -1);

    // zero width: nothing kept, vs still follows
    set_win(2, 1, 0, 2);
    drive_frame(8, 4, 0, -1, 0, -1, -1);

    // window past the last line: truncated, also short
    set_win(1, 2, 2, 5);
    drive_frame(8, 4, 0, -1, 0, -1, -1);

    // reset during a kept pixel, bypass for the rest, crop again afterwards
    set_win(2, 1, 3, 2);
    drive_frame(8, 4, 0, -1, 0, 1, 3);
    drive_frame(8, 4, 0, -1, 0, -1, -1);
    drive_frame(8, 4, 0, -1, 0, -1, -1);

    // closing vs to check the last frame's status, then drain
    drive_frame(8, 0, 0, -1, 0, -1, -1);
    repeat (4) drive(1'b0, 1'b0, '0, 1'b0);
    check_eq("sb_final_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
